uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART_N transmitter between req_count requesters. It drives the transmitter's write/T_W inputs and tracks its T_locked status. Each granted request is sequenced through issue, lock acknowledge and frame completion. It sits between internal producers (counter, string container, debug logic) and the UART_N instance.

Parameters:
req_count, 4, number of requesters (>=2); idx width IW = $clog2(req_count)
word_width, 8, UART word width; must match UART_N word_width
ack_timeout, 16, cycles allowed between write pulse and T_locked rising (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  req_count  per-requester request level; held until its grant bit pulses
req_data  input  req_count*word_width  flattened words; requester i uses bits [i*word_width +: word_width], stable while req[i]=1
grant  output  req_count  one-hot, one-cycle pulse: word captured, requester may drop req
done  output  1  one-cycle pulse: granted frame fully transmitted
done_id  output  IW  index of finished requester, valid with done or err
err  output  1  one-cycle pulse: T_locked never rose within ack_timeout
busy  output  1  high in any state other than IDLE
write  output  1  to UART_N write, one-cycle pulse
T_W  output  word_width  to UART_N T_W, registered
T_locked  input  1  from UART_N, high while transmitter busy

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ptr=0, idx=0, timer=0. Outputs: grant=0, done=0, err=0, busy=0, write=0, T_W=0, done_id=0. Reset mid-frame abandons the transaction; no done or err is issued.
- All outputs are registered.
- IDLE:
  - If |req and T_locked=0: pick the first i with req[i]=1, scanning ptr, ptr+1, ... with mod req_count wrap.
  - Latch idx=i and T_W=req_data word i; go ISSUE.
  - If T_locked=1 (transmitter busy externally), stay in IDLE and grant nothing.
- ISSUE (exactly 1 cycle): write=1, grant[idx]=1, busy=1; timer=0; go WAIT_LOCK.
  - Latency req rising -> grant/write is 2 clocks when idle.
- WAIT_LOCK:
  - T_locked=1: go WAIT_FREE.
  - Else timer++. When timer==ack_timeout-1 with T_locked still 0: err=1, done_id=idx, ptr=(idx+1) mod req_count, go IDLE.
- WAIT_FREE:
  - Wait for T_locked=0. Then done=1, done_id=idx, ptr=(idx+1) mod req_count, go IDLE.
  - No timeout in this state; frame length is owned by UART_N.
- Fairness: ptr advances only on completion or error, so a granted requester is lowest priority next round. With all requesters active the order is 0,1,2,3,0...
- Simultaneous events:
  - req changes during non-IDLE states are ignored until IDLE.
  - A new req in the same cycle as done is evaluated on the next IDLE cycle, so back-to-back spacing is done -> write in 2 cycles.
  - req[i] dropping before grant is legal (withdrawal); arbitration uses req only in IDLE.
- T_W holds its value until the next capture.
- At most one of grant, done, err is high in any cycle.

Test Plan:
- Single request: reset, req=4'b0100, word 2=8'hA5; UART model locks 2 cycles after write and releases 40 cycles later -> grant=4'b0100 and write=1 on cycle 2, T_W=8'hA5, then one done pulse with done_id=2, busy=0 the next cycle.
- Round robin: req=4'b1111 held, each requester dropping its req on grant -> grant order 0,1,2,3, four done pulses with done_id 0,1,2,3. Re-assert req=4'b1111 -> next grant goes to 0.
- Fairness after wrap: ptr=3, req=4'b1001 -> grant[3] first, then grant[0].
- Timeout: T_locked tied 0, req=4'b0010 -> write pulse, then err=1 with done_id=1 exactly ack_timeout=16 cycles later, no done. A next request of 4'b0011 grants index 2 wrap search -> grant[0] (ptr=2, first set bit found is 0).
- External lock: T_locked=1 held in IDLE with req=4'b0001 -> no grant or write. Release T_locked -> grant[0] 2 cycles later.
- Async reset mid-frame: assert rst_n=0 during WAIT_FREE off a clock edge -> all outputs 0 immediately, no done. After release, req=4'b0001 -> normal transaction.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART_N transmitter between req_count producers.
// Each grant runs through write issue, lock acknowledge from the UART and frame completion.
module uart_tx_arbiter #(
    parameter int req_count   = 4,
    parameter int word_width  = 8,
    parameter int ack_timeout = 16,
    localparam int IW = $clog2(req_count),
    localparam int TW = $clog2(ack_timeout)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [req_count-1:0]            req,
    input  logic [req_count*word_width-1:0] req_data,
    output logic [req_count-1:0]            grant,
    output logic                            done,
    output logic [IW-1:0]                   done_id,
    output logic                            err,
    output logic                            busy,
    output logic                            write,
    output logic [word_width-1:0]           T_W,
    input  logic                            T_locked
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_LOCK = 2'd2,
        ST_WAIT_FREE = 2'd3
    } state_t;

    state_t                  state_q;
    logic [IW-1:0]           ptr_q;
    logic [IW-1:0]           idx_q;
    logic [TW-1:0]           timer_q;
    logic [req_count-1:0]    grant_q;
    logic                    done_q;
    logic                    err_q;
    logic                    busy_q;
    logic                    write_q;
    logic [word_width-1:0]   tw_q;
    logic [IW-1:0]           done_id_q;

    logic [IW-1:0]           pick_d;
    logic [IW:0]             cand_d;
    logic [word_width-1:0]   word_d;
    logic [IW-1:0]           ptr_adv_d;

    // Round-robin search from ptr: scanning offsets high to low lets the nearest match win.
    always_comb begin
        pick_d = ptr_q;
        cand_d = '0;
        for (int k = req_count - 1; k >= 0; k--) begin
            cand_d = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand_d >= (IW+1)'(req_count)) begin
                cand_d = cand_d - (IW+1)'(req_count);
            end else begin
                cand_d = cand_d;
            end
            if (req[cand_d[IW-1:0]]) begin
                pick_d = cand_d[IW-1:0];
            end else begin
                pick_d = pick_d;
            end
        end
    end

    // Word of the winning requester and the pointer value that follows the current owner.
    always_comb begin
        word_d = req_data[int'(pick_d) * word_width +: word_width];
        if (idx_q == IW'(req_count - 1)) begin
            ptr_adv_d = '0;
        end else begin
            ptr_adv_d = idx_q + IW'(1);
        end
    end

    // Sequencing FSM; every output is a register updated from the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            grant_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            write_q   <= 1'b0;
            tw_q      <= '0;
            done_id_q <= '0;
        end else begin
            grant_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            busy_q  <= (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if ((|req) && !T_locked) begin
                        idx_q   <= pick_d;
                        tw_q    <= word_d;
                        state_q <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    write_q <= 1'b1;
                    grant_q <= req_count'(1'b1) << idx_q;
                    timer_q <= '0;
                    state_q <= ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (T_locked) begin
                        state_q <= ST_WAIT_FREE;
                    end else if (timer_q == TW'(ack_timeout - 1)) begin
                        err_q     <= 1'b1;
                        done_id_q <= idx_q;
                        ptr_q     <= ptr_adv_d;
                        state_q   <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_WAIT_FREE: begin
                    // Frame length belongs to UART_N, so there is deliberately no timeout here.
                    if (!T_locked) begin
                        done_q    <= 1'b1;
                        done_id_q <= idx_q;
                        ptr_q     <= ptr_adv_d;
                        state_q   <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT_FREE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign write   = write_q;
    assign T_W     = tw_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: the bench plays the UART_N lock/release
// behaviour and predicts grants from a round-robin pointer kept as a plain integer.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int WW = 8;
    localparam int AT = 16;
    localparam int IW = $clog2(N);

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*WW-1:0]   req_data;
    logic [N-1:0]      grant;
    logic              done;
    logic [IW-1:0]     done_id;
    logic              err;
    logic              busy;
    logic              write;
    logic [WW-1:0]     T_W;
    logic              T_locked;

    int checks;
    int errors;
    int ptr_m;
    logic [WW-1:0] words_m [N];

    uart_tx_arbiter #(.req_count(N), .word_width(WW), .ack_timeout(AT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .done_id(done_id), .err(err),
        .busy(busy), .write(write), .T_W(T_W), .T_locked(T_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic apply_req(input logic [N-1:0] nr);
        for (int i = 0; i < N; i++) begin
            if (nr[i] && !req[i]) begin
                words_m[i] = WW'($urandom);
                req_data[i*WW +: WW] = words_m[i];
            end
        end
        req = nr;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {grant, done, err, busy, write, T_W, done_id}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        T_locked = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all_zero("reset_outputs");
        ptr_m = 0;
    endtask

    // Caller has just driven a non-zero req right after a sample point while the DUT is idle.
    task automatic run_txn(input bit timeout, input int lock_a, input int hold);
        int exp_i;
        int bad;
        exp_i = rr_pick(req, ptr_m);
        if (exp_i < 0) begin
            check_eq("req_nonzero", 32'd0, 32'd1);
            exp_i = 0;
        end
        tick();
        check_eq("issue_quiet", {write, |grant, busy}, 32'd0);
        tick();
        check_eq("write", write, 32'd1);
        check_eq("grant", grant, 32'd1 << exp_i);
        check_eq("T_W", T_W, words_m[exp_i]);
        check_eq("busy", busy, 32'd1);
        req[exp_i] = 1'b0;
        bad = 0;
        if (timeout) begin
            for (int j = 1; j < AT; j++) begin
                tick();
                bad += int'(write | done | err | (|grant));
            end
            check_eq("timeout_quiet", bad, 32'd0);
            tick();
            check_eq("err", err, 32'd1);
            check_eq("err_no_done", {done, |grant}, 32'd0);
            check_eq("err_id", done_id, exp_i);
        end else begin
            for (int j = 0; j < lock_a; j++) begin
                tick();
                bad += int'(write | done | err | (|grant));
            end
            T_locked = 1'b1;
            for (int j = 0; j < hold; j++) begin
                tick();
                bad += int'(write | done | err | (|grant));
            end
            T_locked = 1'b0;
            check_eq("frame_quiet", bad, 32'd0);
            tick();
            check_eq("done", done, 32'd1);
            check_eq("done_no_err", {err, |grant}, 32'd0);
            check_eq("done_id", done_id, exp_i);
        end
        ptr_m = (exp_i + 1) % N;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] nr;
        int bad;
        checks = 0;
        errors = 0;
        req_data = '0;
        do_reset();

        // Single request with a fixed word, lock after 2 cycles, release 40 later.
        apply_req(4'b0100);
        words_m[2] = 8'hA5;
        req_data[2*WW +: WW] = 8'hA5;
        run_txn(1'b0, 2, 40);

        // Round robin from a fresh pointer, then re-assert everybody.
        do_reset();
        apply_req(4'b1111);
        for (int t = 0; t < N; t++) run_txn(1'b0, $urandom_range(0, AT-1), $urandom_range(1, 10));
        apply_req(4'b1111);
        check_eq("rr_restart_ptr", rr_pick(req, ptr_m), 32'd0);
        run_txn(1'b0, 1, 5);
        apply_req(4'b0000);

        // Move pointer to 3, then wrap fairness with 1001.
        apply_req(4'b0100);
        run_txn(1'b0, 0, 3);
        apply_req(4'b1001);
        run_txn(1'b0, 3, 4);
        run_txn(1'b0, AT-1, 4);

        // Lock never arrives, then wrap search from ptr=2.
        apply_req(4'b0010);
        run_txn(1'b1, 0, 0);
        apply_req(4'b0011);
        run_txn(1'b0, 2, 6);
        apply_req(4'b0000);

        // Transmitter held externally while idle.
        T_locked = 1'b1;
        apply_req(4'b0001);
        bad = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            bad += int'(write | (|grant) | busy);
        end
        check_eq("ext_lock_quiet", bad, 32'd0);
        T_locked = 1'b0;
        run_txn(1'b0, 2, 8);

        // Randomized traffic with withdrawals and occasional timeouts.
        for (int t = 0; t < 40; t++) begin
            nr = (req & N'($urandom)) | (N'($urandom) & N'($urandom));
            if (nr == '0) nr[$urandom_range(0, N-1)] = 1'b1;
            apply_req(nr);
            run_txn($urandom_range(0, 5) == 0, $urandom_range(0, AT-1), $urandom_range(1, 20));
        end
        apply_req(4'b0000);
        tick();
        check_eq("final_idle_busy", busy, 32'd0);

        // Asynchronous reset in the middle of a frame.
        apply_req(4'b0010);
        tick();
        tick();
        check_eq("pre_reset_write", write, 32'd1);
        req[1] = 1'b0;
        T_locked = 1'b1;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        T_locked = 1'b0;
        bad = 0;
        for (int j = 0; j < 3; j++) begin
            tick();
            bad += int'(done | err | write | busy);
        end
        check_eq("reset_no_done", bad, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        ptr_m = 0;
        apply_req(4'b0001);
        run_txn(1'b0, 2, 12);
        tick();
        check_eq("post_reset_busy", busy, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
